// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side sequencer, captures uart_rx bytes + error flags into a show-ahead FIFO
// Ports: mclkx16/reset_n clock and async active-low reset; rx_* receiver handshake (rx_read strobe out);
//        m_valid/m_data/m_ready host stream; flush sync FIFO clear; level/full occupancy.
// Optional: define UART_RX_ERRCNT_EN to add saturating cnt_parity/cnt_framing/cnt_overrun outputs.
module uart_rx_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          mclkx16,
  input  logic          reset_n,
  input  logic [7:0]    rx_rdata,
  input  logic          rx_rxrdy,
  input  logic          rx_parityerr,
  input  logic          rx_framingerr,
  input  logic          rx_overrun,
  output logic          rx_read,
  output logic          m_valid,
  output logic [10:0]   m_data,
  input  logic          m_ready,
  input  logic          flush,
  output logic [AW:0]   level,
`ifdef UART_RX_ERRCNT_EN
  output logic [7:0]    cnt_parity,
  output logic [7:0]    cnt_framing,
  output logic [7:0]    cnt_overrun,
`endif
  output logic          full
);
  localparam logic [1:0] IDLE = 2'd0, ACK = 2'd1, WAIT = 2'd2;
  logic [1:0]    r_state;
  logic          r_read, r_valid;
  logic [10:0]   r_data;
  logic [AW:0]   r_level;
  logic [AW-1:0] r_wr, r_rd;
  logic [10:0]   r_mem [DEPTH];
  logic          w_full, w_push, w_wr_en, w_pop;
  logic [AW-1:0] w_rd_nxt;
  logic [AW:0]   w_lvl_nxt, w_lvl_old;
  assign w_full   = r_level == (AW+1)'(DEPTH);
  assign w_push   = r_state == IDLE && rx_rxrdy && !w_full;
  assign w_wr_en  = w_push && !flush;
  assign w_pop    = r_valid && m_ready;
  assign w_rd_nxt = flush ? '0 : r_rd + AW'(w_pop);
  assign w_lvl_nxt = flush ? '0 : r_level + (AW+1)'(w_wr_en) - (AW+1)'(w_pop);
  // occupancy ignoring this edge's push: a fresh entry becomes visible one cycle later
  assign w_lvl_old = flush ? '0 : r_level - (AW+1)'(w_pop);
  assign rx_read = r_read;
  assign m_valid = r_valid;
  assign m_data  = r_data;
  assign level   = r_level;
  assign full    = w_full;
  always_ff @(posedge mclkx16 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_read  <= 1'b0;
    end else begin
      r_state <= r_state == IDLE ? (w_push ? ACK : IDLE) : r_state == ACK ? WAIT : (rx_rxrdy ? WAIT : IDLE);
      r_read  <= w_push || r_state == ACK || (r_state == WAIT && rx_rxrdy);
    end
  end
  always_ff @(posedge mclkx16 or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_wr    <= flush ? '0 : r_wr + AW'(w_wr_en);
      r_rd    <= w_rd_nxt;
      r_level <= w_lvl_nxt;
      r_valid <= w_lvl_old != '0;
      r_data  <= r_mem[w_rd_nxt];
    end
  end
  always_ff @(posedge mclkx16) begin
    if (w_wr_en) r_mem[r_wr] <= {rx_overrun, rx_framingerr, rx_parityerr, rx_rdata};
  end
`ifdef UART_RX_ERRCNT_EN
  logic [7:0] r_cnt_p, r_cnt_f, r_cnt_o;
  assign cnt_parity  = r_cnt_p;
  assign cnt_framing = r_cnt_f;
  assign cnt_overrun = r_cnt_o;
  always_ff @(posedge mclkx16 or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_p <= '0;
      r_cnt_f <= '0;
      r_cnt_o <= '0;
    end else begin
      r_cnt_p <= flush ? 8'd0 : (w_wr_en && rx_parityerr && r_cnt_p != 8'hFF) ? r_cnt_p + 8'd1 : r_cnt_p;
      r_cnt_f <= flush ? 8'd0 : (w_wr_en && rx_framingerr && r_cnt_f != 8'hFF) ? r_cnt_f + 8'd1 : r_cnt_f;
      r_cnt_o <= flush ? 8'd0 : (w_wr_en && rx_overrun && r_cnt_o != 8'hFF) ? r_cnt_o + 8'd1 : r_cnt_o;
    end
  end
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl with a queue-based reference model
module tb_uart_rx_ctrl;
  localparam int DEPTH = 8;
  logic clk = 0, reset_n = 0;
  logic [7:0] rx_rdata = 0;
  logic rx_rxrdy = 0, pe = 0, fe = 0, ov = 0, m_ready = 0, flush = 0;
  logic rx_read, m_valid, full;
  logic [10:0] m_data;
  logic [3:0] level;
`ifdef UART_RX_ERRCNT_EN
  logic [7:0] cnt_parity, cnt_framing, cnt_overrun;
`endif
  always #5 clk = ~clk;
  uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
    .mclkx16(clk), .reset_n(reset_n), .rx_rdata(rx_rdata), .rx_rxrdy(rx_rxrdy),
    .rx_parityerr(pe), .rx_framingerr(fe), .rx_overrun(ov), .rx_read(rx_read),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .flush(flush), .level(level),
`ifdef UART_RX_ERRCNT_EN
    .cnt_parity(cnt_parity), .cnt_framing(cnt_framing), .cnt_overrun(cnt_overrun),
`endif
    .full(full)
  );
  int total = 0, bad = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  typedef struct { logic [10:0] d; int t; } ent_t;
  ent_t q[$];
  int cyc = 0, busy = 0;
  logic [7:0] mp = 0, mf = 0, mo = 0;
  function automatic logic exp_valid();
    return q.size() == 0 ? 1'b0 : cyc > q[0].t;
  endfunction
  always @(posedge clk or negedge reset_n) begin
    logic pop, cap;
    if (!reset_n) begin
      q.delete(); cyc = 0; busy = 0; mp = 0; mf = 0; mo = 0;
    end else begin
      pop = exp_valid() && m_ready;
      cap = busy == 0 && rx_rxrdy && q.size() < DEPTH;
      cyc++;
      if (flush) begin
        q.delete(); mp = 0; mf = 0; mo = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (cap) begin
          q.push_back('{d: {ov, fe, pe, rx_rdata}, t: cyc});
          if (pe && mp != 8'hFF) mp++;
          if (fe && mf != 8'hFF) mf++;
          if (ov && mo != 8'hFF) mo++;
        end
      end
      busy = cap ? 1 : busy == 1 ? 2 : (busy == 2 && !rx_rxrdy) ? 0 : busy;
    end
  end
  always @(negedge clk) begin
    if (reset_n) begin
      chk("rx_read", rx_read, busy != 0);
      chk("level", level, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("m_valid", m_valid, exp_valid());
      if (exp_valid()) chk("m_data", m_data, q[0].d);
`ifdef UART_RX_ERRCNT_EN
      chk("cnt_parity", cnt_parity, mp);
      chk("cnt_framing", cnt_framing, mf);
      chk("cnt_overrun", cnt_overrun, mo);
`endif
    end
  end
  task automatic step();
    @(negedge clk);
    if (rx_read) rx_rxrdy = 0;
  endtask
  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic wait_idle();
    int k = 0;
    while ((rx_rxrdy || rx_read) && k < 50) begin step(); k++; end
    if (k >= 50) begin
      total++; bad++;
      $display("FAIL handshake_timeout: rx_rxrdy=%0b rx_read=%0b required both 0", rx_rxrdy, rx_read);
    end
  endtask
  task automatic send(logic [7:0] d, logic p, logic f, logic o);
    wait_idle();
    rx_rdata = d; pe = p; fe = f; ov = o; rx_rxrdy = 1;
  endtask
  task automatic drain();
    int k = 0;
    m_ready = 1;
    while (level != 0 && k < 100) begin step(); k++; end
    if (k >= 100) begin
      total++; bad++;
      $display("FAIL drain_timeout: level=%0d required 0", level);
    end
    m_ready = 0;
    wait_idle();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    steps(2);
    chk("rst_rx_read", rx_read, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    #2 reset_n = 1;
    // single byte, host always ready
    m_ready = 1;
    send(8'hA5, 0, 0, 0);
    step();
    chk("t1_read_n", rx_read, 1); chk("t1_level_n", level, 1); chk("t1_valid_n", m_valid, 0);
    step();
    chk("t1_read_n1", rx_read, 1); chk("t1_valid_n1", m_valid, 1); chk("t1_data_n1", m_data, 11'h0A5);
    step();
    chk("t1_read_n2", rx_read, 0); chk("t1_level_n2", level, 0); chk("t1_valid_n2", m_valid, 0);
    m_ready = 0;
    // fill to full; ninth byte must wait in the receiver
    for (int i = 0; i < 9; i++) begin
      send(8'h10 + 8'(i), 0, 0, 0);
      step();
    end
    steps(4);
    chk("t2_level", level, 8); chk("t2_full", full, 1); chk("t2_read", rx_read, 0);
    m_ready = 1;
    step();
    m_ready = 0;
    step();
    chk("t2_cap_read", rx_read, 1); chk("t2_cap_level", level, 8);
    drain();
    // error flags
    send(8'h3C, 1, 1, 0);
    steps(2);
    chk("t3_valid", m_valid, 1); chk("t3_data", m_data, 11'h33C);
`ifdef UART_RX_ERRCNT_EN
    chk("t3_cnt_p", cnt_parity, 1); chk("t3_cnt_f", cnt_framing, 1); chk("t3_cnt_o", cnt_overrun, 0);
`endif
    drain();
    // push and pop together at level 3, across pointer wrap
    for (int i = 0; i < 3; i++) begin
      send(8'h40 + 8'(i), 0, 0, 0);
      step();
    end
    wait_idle();
    chk("t4_level_pre", level, 3);
    for (int i = 0; i < 20; i++) begin
      send(8'h80 + 8'(i * 7), i % 3 == 0, i % 5 == 0, i % 2 == 0);
      m_ready = 1;
      step();
      m_ready = 0;
      chk("t4_level", level, 3);
    end
    drain();
    // flush coinciding with a push at level 5
    for (int i = 0; i < 5; i++) begin
      send(8'hC0 + 8'(i), 0, 0, 1);
      step();
    end
    wait_idle();
    chk("t5_level_pre", level, 5);
    send(8'hEE, 1, 1, 1);
    flush = 1;
    step();
    flush = 0;
    chk("t5_level", level, 0); chk("t5_valid", m_valid, 0); chk("t5_read_n", rx_read, 1);
`ifdef UART_RX_ERRCNT_EN
    chk("t5_cnt_o", cnt_overrun, 0);
`endif
    step();
    chk("t5_read_n1", rx_read, 1);
    step();
    chk("t5_read_n2", rx_read, 0);
    // reset during ACK with rxrdy still pending
    send(8'h5A, 0, 0, 0);
    @(negedge clk);
    chk("t6_read_ack", rx_read, 1);
    #2 reset_n = 0;
    #1;
    chk("t6_rst_read", rx_read, 0); chk("t6_rst_level", level, 0); chk("t6_rst_valid", m_valid, 0);
    @(negedge clk);
    #2 reset_n = 1;
    step();
    chk("t6_recap_read", rx_read, 1); chk("t6_recap_level", level, 1);
    step();
    chk("t6_recap_data", m_data, 11'h05A);
    drain();
    steps(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
